// File: rtl/flags_stack.sv
// Flag register with masked load and a small save/restore stack.
// Sticky overflow/underflow errors report misuse of push and pop.
module flags_stack #(
   parameter int WIDTH = 6,
   parameter int DEPTH = 4,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] inp,
   input  logic [WIDTH-1:0] mask,
   input  logic             control,
   input  logic             push,
   input  logic             pop,
   input  logic             clr_err,
   output logic [WIDTH-1:0] out,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty,
   output logic             overflow,
   output logic             underflow
);

   logic [WIDTH-1:0] r_stack [DEPTH];
   logic [WIDTH-1:0] r_out;
   logic [CW-1:0]    r_count;
   logic             r_ovf;
   logic             r_unf;

   logic [WIDTH-1:0] w_top;
   logic [WIDTH-1:0] w_load;
   logic             w_full;
   logic             w_empty;
   logic             w_push_ok;
   logic             w_pop_ok;
   logic             w_pop_only;
   logic             w_swap;
   logic             w_ovf_evt;
   logic             w_unf_evt;

   assign w_full     = (r_count == CW'(DEPTH));
   assign w_empty    = (r_count == '0);
   assign w_push_ok  = push & ~pop & ~w_full;
   assign w_pop_ok   = pop & ~w_empty;
   assign w_pop_only = pop & ~push & ~w_empty;
   assign w_swap     = push & pop & ~w_empty;
   assign w_ovf_evt  = push & ~pop & w_full;
   assign w_unf_evt  = pop & w_empty;
   assign w_load     = (r_out & ~mask) | (inp & mask);

   // Read mux for the top entry, decoded from count to avoid index truncation.
   always_comb begin
      w_top = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (r_count == CW'(i + 1)) w_top = r_stack[i];
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (w_push_ok && r_count == CW'(i)) r_stack[i] <= r_out;
         if (w_swap && r_count == CW'(i + 1)) r_stack[i] <= r_out;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out   <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end else begin
         // A successful restore (pop or swap) overrides any load.
         if (w_pop_ok) r_out <= w_top;
         else if (control) r_out <= w_load;

         if (w_push_ok) r_count <= r_count + CW'(1);
         else if (w_pop_only) r_count <= r_count - CW'(1);

         if (w_ovf_evt) r_ovf <= 1'b1;
         else if (clr_err) r_ovf <= 1'b0;

         if (w_unf_evt) r_unf <= 1'b1;
         else if (clr_err) r_unf <= 1'b0;
      end
   end

   assign out       = r_out;
   assign count     = r_count;
   assign full      = w_full;
   assign empty     = w_empty;
   assign overflow  = r_ovf;
   assign underflow = r_unf;

endmodule
